// File: rtl/adc_serial_sampler_if.sv
// Pin bundle between the sampler and an LTC2308-type serial ADC.
// The master drives CONVST/SCK/SDI and the ADC returns SDO.
interface adc_serial_sampler_if;
  logic adc_convst;
  logic adc_sck;
  logic adc_sdi;
  logic adc_sdo;

  modport master (
    output adc_convst,
    output adc_sck,
    output adc_sdi,
    input  adc_sdo
  );

  modport slave (
    input  adc_convst,
    input  adc_sck,
    input  adc_sdi,
    output adc_sdo
  );
endinterface

// File: rtl/adc_serial_sampler.sv
// Periodic sampler for a 12-bit SPI-style ADC.
// Each result is presented with a one-cycle strobe.
module adc_serial_sampler #(
  parameter int SAMPLE_PERIOD = 1134,
  parameter int CONV_CYCLES   = 80,
  parameter int CLK_DIV       = 2,
  parameter int CHANNEL       = 0
) (
  input  logic                        CLOCK,
  input  logic                        RESET,
  input  logic                        enable,
  adc_serial_sampler_if.master        adc,
  output logic [11:0]                 adc_measurements,
  output logic                        received_measurement,
  output logic                        overrun
);

  localparam int PW = (SAMPLE_PERIOD > 1) ?
                      $clog2(SAMPLE_PERIOD) : 1;
  localparam int CMAX = (CONV_CYCLES > 2 * CLK_DIV) ?
                        CONV_CYCLES : 2 * CLK_DIV;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [2:0] CH = 3'(CHANNEL);
  // Config word, MSB first: SD, O/S, S1, S0, UNI, SLP, then zeros.
  localparam logic [11:0] CFG = {
    1'b1, CH[0], CH[2], CH[1], 1'b1, 1'b0, 6'b0
  };

  typedef enum logic [2:0] {
    IDLE, CONVST, CONVERT, SHIFT, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   per_q, per_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [11:0]     shreg_q, shreg_d;
  logic [11:0]     meas_q, meas_d;
  logic            strobe_q, strobe_d;
  logic            overrun_q, overrun_d;
  logic            convst_q, convst_d;
  logic            sck_q, sck_d;
  logic            sdi_q, sdi_d;
  logic            tick;

  // Period counter, transaction FSM and all registered pin values.
  always_comb begin
    tick      = enable && (per_q == '0);
    per_d     = '0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    meas_d    = meas_q;
    strobe_d  = 1'b0;
    overrun_d = overrun_q;
    convst_d  = convst_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;

    if (enable) begin
      per_d = (per_q == PW'(SAMPLE_PERIOD - 1)) ?
              '0 : per_q + 1'b1;
    end

    // A tick that finds the FSM busy is lost; flag it.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        convst_d = 1'b0;
        sck_d    = 1'b0;
        sdi_d    = 1'b0;
        if (tick) begin
          state_d  = CONVST;
          convst_d = 1'b1;
          cnt_d    = '0;
        end
      end
      CONVST: begin
        if (cnt_q == CW'(1)) begin
          state_d  = CONVERT;
          convst_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = '0;
          sck_d   = 1'b0;
          sdi_d   = CFG[11];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // SDO is captured on the edge that raises SCK.
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          sck_d   = 1'b1;
          shreg_d = {shreg_q[10:0], adc.adc_sdo};
        end
        if (cnt_q == CW'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          sck_d = 1'b0;
          if (bit_q == 4'd11) begin
            state_d  = DONE;
            sdi_d    = 1'b0;
            strobe_d = 1'b1;
            meas_d   = shreg_q;
          end else begin
            bit_d = bit_q + 1'b1;
            sdi_d = CFG[4'd10 - bit_q];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      per_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      meas_q    <= '0;
      strobe_q  <= 1'b0;
      overrun_q <= 1'b0;
      convst_q  <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      meas_q    <= meas_d;
      strobe_q  <= strobe_d;
      overrun_q <= overrun_d;
      convst_q  <= convst_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
    end
  end

  assign adc.adc_convst          = convst_q;
  assign adc.adc_sck             = sck_q;
  assign adc.adc_sdi             = sdi_q;
  assign adc_measurements        = meas_q;
  assign received_measurement    = strobe_q;
  assign overrun                 = overrun_q;

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Directed bench for adc_serial_sampler.
// Two instances: default period and a short overrunning period.
module tb_adc_serial_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [11:0] meas_a, meas_b;
  logic        stb_a, stb_b;
  logic        ovr_a, ovr_b;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_chk = 0;
  int          t0, tb0, t1, t2, t3;

  adc_serial_sampler_if ifa();
  adc_serial_sampler_if ifb();

  adc_serial_sampler dut_a (
    .CLOCK                (clk),
    .RESET                (rst_n),
    .enable               (en_a),
    .adc                  (ifa),
    .adc_measurements     (meas_a),
    .received_measurement (stb_a),
    .overrun              (ovr_a)
  );

  adc_serial_sampler #(.SAMPLE_PERIOD(100)) dut_b (
    .CLOCK                (clk),
    .RESET                (rst_n),
    .enable               (en_b),
    .adc                  (ifb),
    .adc_measurements     (meas_b),
    .received_measurement (stb_b),
    .overrun              (ovr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model A: new word per CONVST, SDO advances after each SCK rise.
  logic [11:0] wa [8] = '{12'hA5C, 12'h000, 12'hFFF, 12'h3C6,
                          12'h5A5, 12'h777, 12'h9E1, 12'h111};
  int          nconv_a = 0;
  int          nrise_a = 0;
  int          bit_a = 0;
  logic [11:0] cur_a = '0;
  logic [11:0] sdi_a = '0;
  time         rise_a [2];

  always @(posedge ifa.adc_convst or posedge ifa.adc_sck) begin
    if (ifa.adc_convst) begin
      cur_a = wa[nconv_a % 8];
      nconv_a++;
      nrise_a = 0;
      bit_a = 11;
      sdi_a = '0;
      ifa.adc_sdo = cur_a[11];
    end else begin
      if (nrise_a < 12) sdi_a[11 - nrise_a] = ifa.adc_sdi;
      if (nrise_a < 2) rise_a[nrise_a] = $time;
      nrise_a++;
      bit_a--;
      ifa.adc_sdo = (bit_a >= 0) ? cur_a[bit_a] : 1'b0;
    end
  end

  // ADC model B.
  logic [11:0] wb [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  int          nconv_b = 0;
  int          bit_b = 0;
  logic [11:0] cur_b = '0;

  always @(posedge ifb.adc_convst or posedge ifb.adc_sck) begin
    if (ifb.adc_convst) begin
      cur_b = wb[nconv_b % 4];
      nconv_b++;
      bit_b = 11;
      ifb.adc_sdo = cur_b[11];
    end else begin
      bit_b--;
      ifb.adc_sdo = (bit_b >= 0) ? cur_b[bit_b] : 1'b0;
    end
  end

  // Strobe monitor.
  int          sta[$];
  logic [11:0] sva[$];
  int          rla[$];
  int          stq_b[$];
  logic [11:0] svb[$];

  always @(negedge clk) begin
    if (stb_a) begin
      sta.push_back(cyc);
      sva.push_back(meas_a);
      rla.push_back(nrise_a);
    end
    if (stb_b) begin
      stq_b.push_back(cyc);
      svb.push_back(meas_b);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_convst"}, 32'(ifa.adc_convst), 0);
    check({tag, "_sck"}, 32'(ifa.adc_sck), 0);
    check({tag, "_sdi"}, 32'(ifa.adc_sdi), 0);
    check({tag, "_meas"}, 32'(meas_a), 0);
    check({tag, "_stb"}, 32'(stb_a), 0);
    check({tag, "_ovr"}, 32'(ovr_a), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    at(cyc + 2);

    // Single sample, then periodic 000/FFF.
    t0 = cyc;
    en_a = 1'b1;
    check("convst_t0", 32'(ifa.adc_convst), 0);
    at(t0 + 1);
    check("convst_t1", 32'(ifa.adc_convst), 1);
    at(t0 + 2);
    check("convst_t2", 32'(ifa.adc_convst), 1);
    at(t0 + 3);
    check("convst_t3", 32'(ifa.adc_convst), 0);
    at(t0 + 130);
    check("stb_t130", 32'(stb_a), 0);
    at(t0 + 131);
    check("stb_t131", 32'(stb_a), 1);
    check("no_early_stb", 32'(sta.size()), 0);
    check("meas_a5c", 32'(meas_a), 'hA5C);
    check("sdi_word", 32'(sdi_a), 'h880);
    check("sck_rises", 32'(nrise_a), 12);
    check("sck_period",
          32'(int'((rise_a[1] - rise_a[0]) / 10)), 4);
    at(t0 + 131 + 1134);
    check("meas_000", 32'(meas_a), 'h000);
    check("stb_p1", 32'(stb_a), 1);
    at(t0 + 131 + 2268);
    check("meas_fff", 32'(meas_a), 'hFFF);
    en_a = 1'b0;
    at(t0 + 2400);
    check("stb_count3", 32'(sta.size()), 3);
    check("stb0_time", 32'(sta[0] - t0), 131);
    check("interval1", 32'(sta[1] - sta[0]), 1134);
    check("interval2", 32'(sta[2] - sta[1]), 1134);
    check("rises_p1", 32'(rla[1]), 12);
    check("rises_p2", 32'(rla[2]), 12);
    check("ovr_a_zero", 32'(ovr_a), 0);

    // Overrun with a 100-cycle period.
    at(cyc + 5);
    tb0 = cyc;
    en_b = 1'b1;
    at(tb0 + 99);
    check("ovr_b_t99", 32'(ovr_b), 0);
    at(tb0 + 101);
    check("ovr_b_t101", 32'(ovr_b), 1);
    at(tb0 + 560);
    en_b = 1'b0;
    check("ovr_b_sticky", 32'(ovr_b), 1);
    check("b_count", 32'(stq_b.size()), 3);
    check("b_t0", 32'(stq_b[0] - tb0), 131);
    check("b_t1", 32'(stq_b[1] - tb0), 331);
    check("b_t2", 32'(stq_b[2] - tb0), 531);
    check("b_v0", 32'(svb[0]), 'h123);
    check("b_v1", 32'(svb[1]), 'h456);
    check("b_v2", 32'(svb[2]), 'h789);

    // Enable dropped during CONVERT.
    at(cyc + 5);
    t1 = cyc;
    en_a = 1'b1;
    at(t1 + 50);
    en_a = 1'b0;
    at(t1 + 131);
    check("drop_stb", 32'(stb_a), 1);
    check("drop_meas", 32'(meas_a), 'h3C6);
    at(t1 + 1500);
    check("drop_nconv", 32'(nconv_a), 4);
    check("drop_count", 32'(sta.size()), 4);
    check("drop_convst", 32'(ifa.adc_convst), 0);

    // Reset held three cycles mid-SHIFT.
    t2 = cyc;
    en_a = 1'b1;
    at(t2 + 100);
    rst_n = 1'b0;
    en_a = 1'b0;
    at(t2 + 101);
    check_zero("midrst");
    at(t2 + 103);
    rst_n = 1'b1;
    at(t2 + 400);
    check("midrst_count", 32'(sta.size()), 4);
    check("midrst_meas", 32'(meas_a), 0);
    check("midrst_nconv", 32'(nconv_a), 5);

    // Reset mid-CONVERT with enable held high.
    at(cyc + 3);
    t3 = cyc;
    en_a = 1'b1;
    at(t3 + 40);
    rst_n = 1'b0;
    at(t3 + 41);
    rst_n = 1'b1;
    at(t3 + 41 + 130);
    check("rel_stb_early", 32'(stb_a), 0);
    at(t3 + 41 + 131);
    check("rel_stb", 32'(stb_a), 1);
    check("rel_meas", 32'(meas_a), 'h9E1);
    en_a = 1'b0;
    at(t3 + 41 + 133);
    check("rel_count", 32'(sta.size()), 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
